// File: rtl/la_trigger_capture.sv
// ---------------------------------------------------------------------------
// la_trigger_capture
//
// Trigger and capture stage for the logic analyzer. It takes the qualified
// sample stream from the sampler and keeps a configurable number of
// pre-trigger samples in a circular buffer. It then detects a level and/or
// rising-edge trigger and fills the rest of the buffer with post-trigger
// samples. Readout is in trigger-relative order: rd_addr 0 is the oldest
// sample of the capture.
//
// Ports
//   ACLK, ARESET      clock (rising edge) and asynchronous active-high reset
//   sample_valid      qualifies sample_data for one cycle
//   sample_data       probe word
//   arm / abort       single-cycle pulses; abort has priority over arm
//   pretrig_len       pre-trigger sample count, latched on arm
//   trig_mask/value   level compare: bits in mask must equal value
//   trig_edge         bits that must show a 0->1 transition
//   rd_addr / rd_data trigger-relative readout, one-cycle latency
//   busy              capture in progress (PRE, WAIT_TRIG, POST)
//   triggered         trigger seen in the current capture
//   done              capture complete
//   capture_start     physical buffer address of the oldest sample
//   dbg_state         FSM state (IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4)
//
// Handshake: a sample is consumed on every rising edge where sample_valid is
// high. There is no back-pressure. Samples that arrive outside PRE, WAIT_TRIG
// and POST, or in the same cycle as arm or abort, are not stored. They still
// update the edge-detect history.
// ---------------------------------------------------------------------------
module la_trigger_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DEPTH_LOG2-1:0] pretrig_len,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_edge,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] capture_start,
    output logic [2:0]            dbg_state
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] pre_cnt_q;
    logic [DEPTH_LOG2-1:0] post_cnt_q;
    logic [DEPTH_LOG2-1:0] p_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DEPTH_LOG2-1:0] capture_start_q;
    logic                  busy_q;
    logic                  triggered_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  lvl_hit;
    logic                  edg_hit;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] wr_ptr_d;
    logic [DEPTH_LOG2-1:0] pre_cnt_d;
    logic [DEPTH_LOG2-1:0] rd_idx;

    always_comb begin
        wr_en     = 1'b0;
        lvl_hit   = 1'b0;
        edg_hit   = 1'b0;
        hit       = 1'b0;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        pre_cnt_d = pre_cnt_q + PTR_ONE;
        rd_idx    = capture_start_q + rd_addr;

        // The sample in an arm/abort cycle is dropped. The FSM is being
        // re-initialised in that cycle and must not advance wr_ptr.
        wr_en = sample_valid && !arm && !abort &&
                (state_q == ST_PRE || state_q == ST_WAIT || state_q == ST_POST);

        lvl_hit = ((sample_data ^ trig_value) & trig_mask) == '0;
        // Each bit selected by trig_edge must be 0 in prev and 1 now.
        edg_hit = (trig_edge & ~(sample_data & ~prev_q)) == '0;
        hit     = lvl_hit && edg_hit;
    end

    // Buffer RAM. It has no reset, so it can map to a block RAM.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_data;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            pre_cnt_q       <= '0;
            post_cnt_q      <= '0;
            p_q             <= '0;
            prev_q          <= '0;
            capture_start_q <= '0;
            busy_q          <= 1'b0;
            triggered_q     <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            // Edge history tracks the stream in every state.
            if (sample_valid) begin
                prev_q <= sample_data;
            end

            if (abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (arm) begin
                // pretrig_len is DEPTH_LOG2 bits wide, so it can never be
                // larger than DEPTH-1. The clamp needs no extra logic.
                p_q         <= pretrig_len;
                wr_ptr_q    <= '0;
                pre_cnt_q   <= '0;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= (pretrig_len != '0) ? ST_PRE : ST_WAIT;
            end else begin
                case (state_q)
                    ST_PRE: begin
                        if (sample_valid) begin
                            wr_ptr_q  <= wr_ptr_d;
                            pre_cnt_q <= pre_cnt_d;
                            if (pre_cnt_d == p_q) begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (sample_valid) begin
                            wr_ptr_q <= wr_ptr_d;
                            if (hit) begin
                                triggered_q     <= 1'b1;
                                // DEPTH-1-P equals ~P at DEPTH_LOG2 bits.
                                post_cnt_q      <= ~p_q;
                                capture_start_q <= wr_ptr_q - p_q;
                                if (p_q == '1) begin
                                    state_q <= ST_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_POST;
                                end
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample_valid) begin
                            wr_ptr_q   <= wr_ptr_d;
                            post_cnt_q <= post_cnt_q - PTR_ONE;
                            if (post_cnt_q == PTR_ONE) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rd_data       = rd_data_q;
    assign busy          = busy_q;
    assign triggered     = triggered_q;
    assign done          = done_q;
    assign capture_start = capture_start_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_la_trigger_capture.sv
module tb_la_trigger_capture;

  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          arm;
  logic          abort;
  logic [DL-1:0] pretrig_len;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic [DW-1:0] trig_edge;
  logic [DL-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [DL-1:0] capture_start;
  logic [2:0]    dbg_state;

  always #5 ACLK = ~ACLK;

  la_trigger_capture #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .abort(abort), .pretrig_len(pretrig_len),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .triggered(triggered), .done(done),
    .capture_start(capture_start), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // The capture is the list of stored samples. The trigger index t is the
  // first stored index >= P that satisfies the trigger rule. The capture is
  // complete once DEPTH-P samples from t onward have been stored.
  bit          m_busy, m_trig, m_done;
  int          m_p, m_tidx, m_cs;
  logic [7:0]  m_prev;
  logic [7:0]  acc[$];

  task automatic model_reset();
    m_busy = 0; m_trig = 0; m_done = 0;
    m_p = 0; m_tidx = -1; m_cs = 0;
    m_prev = 8'h00;
    acc.delete();
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] d, input logic a, input logic ab);
    bit h;
    int n;
    h = ((((d ^ trig_value) & trig_mask) == 8'h00) &&
         (((d & ~m_prev) & trig_edge) == trig_edge));
    if (ab) begin
      m_busy = 0; m_done = 0;
    end else if (a) begin
      m_p = int'(pretrig_len); acc.delete(); m_tidx = -1;
      m_trig = 0; m_done = 0; m_busy = 1;
    end else if (m_busy && v) begin
      acc.push_back(d);
      n = acc.size();
      if (m_tidx < 0 && (n - 1) >= m_p && h) begin
        m_tidx = n - 1;
        m_trig = 1;
        m_cs   = ((n - 1 - m_p) % DEPTH + DEPTH) % DEPTH;
      end
      if (m_tidx >= 0 && n == m_tidx + DEPTH - m_p) begin
        m_busy = 0; m_done = 1;
      end
    end
    if (v) m_prev = d;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle, advance the model, and check status after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic a, input logic ab);
    sample_valid = v; sample_data = d; arm = a; abort = ab;
    model_cycle(v, d, a, ab);
    @(posedge ACLK); #1;
    sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    check("busy", 32'(busy), 32'(m_busy));
    check("triggered", 32'(triggered), 32'(m_trig));
    check("done", 32'(done), 32'(m_done));
    if (m_trig) check("capture_start", 32'(capture_start), 32'(m_cs));
  endtask

  task automatic arm_cap(input int p);
    pretrig_len = DL'(p);
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic readout();
    logic [DW-1:0] exp_q[$];
    check("done_before_readout", 32'(done), 32'd1);
    if (m_done) begin
      for (int k = 0; k < DEPTH; k++) exp_q.push_back(acc[m_tidx - m_p + k]);
      for (int k = 0; k < DEPTH; k++) begin
        rd_addr = DL'(k);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic read_one(input int k, input logic [7:0] exp, input string tag);
    rd_addr = DL'(k);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESET = 1'b1; sample_valid = 0; sample_data = 0; arm = 0; abort = 0;
    pretrig_len = 0; trig_mask = 0; trig_value = 0; trig_edge = 0; rd_addr = 0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_capture_start", 32'(capture_start), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    ARESET = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Basic capture: ramp 0x10.., level trigger at 0x20, P=4.
    trig_mask = 8'hFF; trig_value = 8'h20; trig_edge = 8'h00;
    arm_cap(4);
    for (int d = 8'h10; d <= 8'h3F && !m_done; d++) step(1'b1, 8'(d), 1'b0, 1'b0);
    check("basic_cs", 32'(capture_start), 32'd12);
    readout();
    read_one(4, 8'h20, "basic_trig_word");

    // Immediate trigger: P=0, both masks clear.
    trig_mask = 8'h00; trig_edge = 8'h00;
    arm_cap(0);
    for (int d = 0; d < 16; d++) step(1'b1, 8'(d), 1'b0, 1'b0);
    check("imm_done", 32'(done), 32'd1);
    check("imm_cs", 32'(capture_start), 32'd0);
    readout();
    read_one(7, 8'h07, "imm_rd7");

    // Rising edge on bit 0, P=2: 1,1,1,0,1 triggers on the fifth sample.
    trig_mask = 8'h00; trig_edge = 8'h01;
    arm_cap(2);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("edge_not_yet", 32'(triggered), 32'd0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    check("edge_hit", 32'(triggered), 32'd1);
    for (int i = 0; i < 20 && !m_done; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    readout();
    read_one(2, 8'h01, "edge_rd2");
    read_one(1, 8'h00, "edge_rd1");

    // Wrap-around: P=3, trigger is the 22nd stored sample (physical 5).
    trig_mask = 8'hFF; trig_value = 8'hAA; trig_edge = 8'h00;
    arm_cap(3);
    for (int i = 0; i < 21; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("wrap_cs", 32'(capture_start), 32'd2);
    for (int i = 0; i < 20 && !m_done; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    readout();
    read_one(3, 8'hAA, "wrap_rd3");

    // Clamp: pretrig_len=15, done on the trigger sample; then a stalled rerun.
    trig_mask = 8'hFF; trig_value = 8'h77;
    for (int run = 0; run < 2; run++) begin
      arm_cap(15);
      for (int i = 0; i < 15; i++) begin
        if (run == 1) step(1'b0, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      end
      if (run == 1) step(1'b0, 8'h77, 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      check("clamp_done_on_trig", 32'(done), 32'd1);
      readout();
      read_one(15, 8'h77, "clamp_rd15");
    end

    // Abort in POST.
    trig_mask = 8'h00; trig_edge = 8'h00;
    arm_cap(2);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_trig_held", 32'(triggered), 32'd1);
    // Arm together with abort: abort wins.
    pretrig_len = 4'd3;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("arm_abort_state", 32'(dbg_state), 32'd0);
    // Re-arm in WAIT_TRIG restarts the pre-trigger count.
    trig_mask = 8'hFF; trig_value = 8'hEE;
    arm_cap(5);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    arm_cap(5);
    check("rearm_trig", 32'(triggered), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !m_done; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    readout();
    read_one(5, 8'hEE, "rearm_rd5");

    // Reset mid-POST.
    trig_mask = 8'h00;
    arm_cap(0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    ARESET = 1'b1;
    #1;
    model_reset();
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_triggered", 32'(triggered), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_cs", 32'(capture_start), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized captures against the model.
    for (int c = 0; c < 10; c++) begin
      trig_mask  = 8'($urandom_range(0, 255)) & 8'h03;
      trig_value = 8'($urandom_range(0, 255));
      trig_edge  = ($urandom_range(0, 3) == 0) ? 8'h04 : 8'h00;
      arm_cap(int'($urandom_range(0, 15)));
      for (int i = 0; i < 300 && !m_done; i++)
        step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (m_done) readout();
      else step(1'b0, 8'h00, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
